float16_adder: RTL and testbench

FLOAT16_ADDER -- requirements
Module: float16_adder

---
 rtl/float16_adder.sv | 263 ++++++++++++++++++++++++++
 tb/tb_float16_adder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/float16_adder.sv
// Five-stage pipelined IEEE-754 binary16 adder: round-to-nearest-even, subnormals flushed to zero.
// Latency 5 edges from sampling to result; accepts one operand pair per cycle with no backpressure.
module float16_adder #(
    parameter int FLOAT_LEN = 16,
    parameter int EXP_LEN   = 5,
    parameter int MANT_LEN  = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [FLOAT_LEN-1:0] a,
    input  logic [FLOAT_LEN-1:0] b,
    output logic [FLOAT_LEN-1:0] result
);

    localparam int SIG_LEN = MANT_LEN + 1;       // significand with hidden bit
    localparam int ALN_LEN = SIG_LEN + 2;        // significand + guard + round
    localparam int EXT_LEN = SIG_LEN + 3;        // significand + guard + round + sticky
    localparam int SHF_LEN = SIG_LEN + ALN_LEN;  // alignment shifter width
    localparam int EXP_W   = EXP_LEN + 2;        // signed working exponent
    localparam int LZ_W    = $clog2(EXT_LEN);

    localparam logic [EXP_LEN-1:0]   EXP_MAX   = '1;
    localparam logic [EXP_LEN-1:0]   ALN_LIMIT = EXP_LEN'(ALN_LEN);
    localparam logic [EXP_W-1:0]     EXP_INF   = EXP_W'((2 ** EXP_LEN) - 1);
    localparam logic [FLOAT_LEN-1:0] QNAN      = {1'b0, EXP_MAX, 1'b1, {(MANT_LEN-1){1'b0}}};

    // ---------------- S1: unpack, classify, order by magnitude ----------------
    logic                 a_sign, b_sign;
    logic [EXP_LEN-1:0]   a_exp, b_exp;
    logic [MANT_LEN-1:0]  a_mant, b_mant;
    logic                 a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [FLOAT_LEN-2:0] a_mag, b_mag;
    logic [SIG_LEN-1:0]   a_sig, b_sig;
    logic                 swap;

    always_comb begin
        a_sign = a[FLOAT_LEN-1];
        b_sign = b[FLOAT_LEN-1];
        a_exp  = a[FLOAT_LEN-2 -: EXP_LEN];
        b_exp  = b[FLOAT_LEN-2 -: EXP_LEN];
        a_mant = a[MANT_LEN-1:0];
        b_mant = b[MANT_LEN-1:0];
        a_zero = (a_exp == '0);
        b_zero = (b_exp == '0);
        a_inf  = (a_exp == EXP_MAX) && (a_mant == '0);
        b_inf  = (b_exp == EXP_MAX) && (b_mant == '0);
        a_nan  = (a_exp == EXP_MAX) && (a_mant != '0);
        b_nan  = (b_exp == EXP_MAX) && (b_mant != '0);
        // A zero exponent field means zero: subnormal mantissa bits are ignored.
        a_mag  = a_zero ? '0 : a[FLOAT_LEN-2:0];
        b_mag  = b_zero ? '0 : b[FLOAT_LEN-2:0];
        a_sig  = a_zero ? '0 : {1'b1, a_mant};
        b_sig  = b_zero ? '0 : {1'b1, b_mant};
        swap   = (b_mag > a_mag);
    end

    logic                 s1_sign_l, s1_sign_s;
    logic [EXP_LEN-1:0]   s1_exp_l, s1_exp_s;
    logic [SIG_LEN-1:0]   s1_sig_l, s1_sig_s;
    logic                 s1_nan, s1_inf, s1_inf_sign;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            s1_sign_l   <= 1'b0;
            s1_sign_s   <= 1'b0;
            s1_exp_l    <= '0;
            s1_exp_s    <= '0;
            s1_sig_l    <= '0;
            s1_sig_s    <= '0;
            s1_nan      <= 1'b0;
            s1_inf      <= 1'b0;
            s1_inf_sign <= 1'b0;
        end else begin
            s1_sign_l   <= swap ? b_sign : a_sign;
            s1_sign_s   <= swap ? a_sign : b_sign;
            s1_exp_l    <= swap ? b_exp : a_exp;
            s1_exp_s    <= swap ? a_exp : b_exp;
            s1_sig_l    <= swap ? b_sig : a_sig;
            s1_sig_s    <= swap ? a_sig : b_sig;
            s1_nan      <= a_nan | b_nan | (a_inf & b_inf & (a_sign ^ b_sign));
            s1_inf      <= a_inf | b_inf;
            s1_inf_sign <= a_inf ? a_sign : b_sign;
        end
    end

    // ---------------- S2: align smaller operand, collect G/R/S ----------------
    logic [EXP_LEN-1:0] exp_diff;
    logic [SHF_LEN-1:0] shift_full;
    logic [ALN_LEN-1:0] aligned;
    logic               sticky;

    always_comb begin
        exp_diff   = s1_exp_l - s1_exp_s;
        shift_full = {s1_sig_s, {ALN_LEN{1'b0}}} >> exp_diff;
        // Beyond ALN_LEN the shifter would drop bits off the bottom, so collapse into sticky.
        if (exp_diff >= ALN_LIMIT) begin
            aligned = '0;
            sticky  = |s1_sig_s;
        end else begin
            aligned = shift_full[SHF_LEN-1 -: ALN_LEN];
            sticky  = |shift_full[SIG_LEN-1:0];
        end
    end

    logic               s2_sign_l, s2_sign_s;
    logic [EXP_LEN-1:0] s2_exp_l;
    logic [SIG_LEN-1:0] s2_sig_l;
    logic [ALN_LEN-1:0] s2_aligned;
    logic               s2_sticky;
    logic               s2_nan, s2_inf, s2_inf_sign;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            s2_sign_l   <= 1'b0;
            s2_sign_s   <= 1'b0;
            s2_exp_l    <= '0;
            s2_sig_l    <= '0;
            s2_aligned  <= '0;
            s2_sticky   <= 1'b0;
            s2_nan      <= 1'b0;
            s2_inf      <= 1'b0;
            s2_inf_sign <= 1'b0;
        end else begin
            s2_sign_l   <= s1_sign_l;
            s2_sign_s   <= s1_sign_s;
            s2_exp_l    <= s1_exp_l;
            s2_sig_l    <= s1_sig_l;
            s2_aligned  <= aligned;
            s2_sticky   <= sticky;
            s2_nan      <= s1_nan;
            s2_inf      <= s1_inf;
            s2_inf_sign <= s1_inf_sign;
        end
    end

    // ---------------- S3: significand add / subtract ----------------
    logic [EXT_LEN-1:0] l_ext, s_ext;
    logic [EXT_LEN:0]   sum;

    always_comb begin
        l_ext = {s2_sig_l, 3'b000};
        s_ext = {s2_aligned, s2_sticky};
        // Operands are magnitude-ordered, so the difference never goes negative.
        if (s2_sign_l ^ s2_sign_s) begin
            sum = {1'b0, l_ext} - {1'b0, s_ext};
        end else begin
            sum = {1'b0, l_ext} + {1'b0, s_ext};
        end
    end

    logic               s3_sign_l, s3_sign_s;
    logic [EXP_LEN-1:0] s3_exp_l;
    logic [EXT_LEN:0]   s3_sum;
    logic               s3_nan, s3_inf, s3_inf_sign;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            s3_sign_l   <= 1'b0;
            s3_sign_s   <= 1'b0;
            s3_exp_l    <= '0;
            s3_sum      <= '0;
            s3_nan      <= 1'b0;
            s3_inf      <= 1'b0;
            s3_inf_sign <= 1'b0;
        end else begin
            s3_sign_l   <= s2_sign_l;
            s3_sign_s   <= s2_sign_s;
            s3_exp_l    <= s2_exp_l;
            s3_sum      <= sum;
            s3_nan      <= s2_nan;
            s3_inf      <= s2_inf;
            s3_inf_sign <= s2_inf_sign;
        end
    end

    // ---------------- S4: normalize ----------------
    logic [LZ_W-1:0]    lz;
    logic               lz_found;
    logic [EXT_LEN-1:0] norm;
    logic [EXP_W-1:0]   exp_n;

    always_comb begin
        lz       = '0;
        lz_found = 1'b0;
        for (int i = EXT_LEN - 1; i >= 0; i--) begin
            if (!lz_found && s3_sum[i]) begin
                lz       = LZ_W'(EXT_LEN - 1 - i);
                lz_found = 1'b1;
            end
        end
        if (s3_sum[EXT_LEN]) begin
            norm  = {s3_sum[EXT_LEN:2], |s3_sum[1:0]};
            exp_n = {{(EXP_W-EXP_LEN){1'b0}}, s3_exp_l} + EXP_W'(1);
        end else begin
            norm  = s3_sum[EXT_LEN-1:0] << lz;
            exp_n = {{(EXP_W-EXP_LEN){1'b0}}, s3_exp_l} - {{(EXP_W-LZ_W){1'b0}}, lz};
        end
    end

    // A clear hidden bit in s4_norm marks an exact zero sum.
    logic               s4_sign, s4_zero_sign;
    logic [EXP_W-1:0]   s4_exp;
    logic [EXT_LEN-1:0] s4_norm;
    logic               s4_nan, s4_inf, s4_inf_sign;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            s4_sign      <= 1'b0;
            s4_zero_sign <= 1'b0;
            s4_exp       <= '0;
            s4_norm      <= '0;
            s4_nan       <= 1'b0;
            s4_inf       <= 1'b0;
            s4_inf_sign  <= 1'b0;
        end else begin
            s4_sign      <= s3_sign_l;
            s4_zero_sign <= s3_sign_l & s3_sign_s;
            s4_exp       <= exp_n;
            s4_norm      <= norm;
            s4_nan       <= s3_nan;
            s4_inf       <= s3_inf;
            s4_inf_sign  <= s3_inf_sign;
        end
    end

    // ---------------- S5: round to nearest even, pack ----------------
    logic                 round_up;
    logic [MANT_LEN:0]    mant_r;
    logic [EXP_W-1:0]     exp_f;
    logic                 underflow, overflow;
    logic [FLOAT_LEN-1:0] result_n;

    always_comb begin
        round_up  = s4_norm[2] & (s4_norm[3] | s4_norm[1] | s4_norm[0]);
        mant_r    = {1'b0, s4_norm[EXT_LEN-2:3]} + {{MANT_LEN{1'b0}}, round_up};
        // A carry out of the mantissa leaves its low bits zero, i.e. 1.0 at the next exponent.
        exp_f     = s4_exp + {{(EXP_W-1){1'b0}}, mant_r[MANT_LEN]};
        underflow = exp_f[EXP_W-1] | (exp_f == '0);
        overflow  = !exp_f[EXP_W-1] && (exp_f >= EXP_INF);
        if (s4_nan) begin
            result_n = QNAN;
        end else if (s4_inf) begin
            result_n = {s4_inf_sign, EXP_MAX, {MANT_LEN{1'b0}}};
        end else if (!s4_norm[EXT_LEN-1]) begin
            result_n = {s4_zero_sign, {(FLOAT_LEN-1){1'b0}}};
        end else if (underflow) begin
            result_n = {s4_sign, {(FLOAT_LEN-1){1'b0}}};
        end else if (overflow) begin
            result_n = {s4_sign, EXP_MAX, {MANT_LEN{1'b0}}};
        end else begin
            result_n = {s4_sign, exp_f[EXP_LEN-1:0], mant_r[MANT_LEN-1:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            result <= '0;
        end else begin
            result <= result_n;
        end
    end

endmodule

// File: tb/tb_float16_adder.sv
// Bench for float16_adder: directed vectors plus a random stream, checked through an expectation queue
// keyed by the cycle each result is due; a reset pulse mid-stream replaces pending expectations with zeros.
module tb_float16_adder;

    logic        clk;
    logic        rst_n;
    logic [15:0] a, b;
    logic [15:0] result;

    float16_adder #(.FLOAT_LEN(16), .EXP_LEN(5), .MANT_LEN(10)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .result (result)
    );

    typedef struct {
        int          due;
        logic [15:0] expv;
        string       name;
    } exp_t;

    exp_t q[$];
    exp_t mon_item;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every cycle with an expectation due is compared against result.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            mon_item = q.pop_front();
            checks++;
            if (mon_item.due != cyc || result !== mon_item.expv) begin
                failures++;
                $display("FAIL %s cyc=%0d due=%0d got=%h want=%h",
                         mon_item.name, cyc, mon_item.due, result, mon_item.expv);
            end
        end
    end

    task automatic push_exp(input int due, input logic [15:0] ev, input string nm);
        exp_t it;
        it.due  = due;
        it.expv = ev;
        it.name = nm;
        q.push_back(it);
    endtask

    // Drive one cycle; the pair is sampled at edge e and its sum is due after edge e+4.
    task automatic drive(input logic r, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] ev, input string nm);
        int e;
        @(negedge clk);
        e     = cyc + 1;
        rst_n = r;
        a     = x;
        b     = y;
        if (r) begin
            while (q.size() > 0 && q[$].due >= e) void'(q.pop_back());
            for (int k = 0; k < 5; k++) push_exp(e + k, 16'h0000, nm);
        end else begin
            push_exp(e + 4, ev, nm);
        end
    endtask

    function automatic real h2r(input logic [15:0] h);
        real v;
        int  e;
        if (h[14:10] == 5'd0) return 0.0;
        v = 1.0 + real'(h[9:0]) / 1024.0;
        e = int'(h[14:10]) - 15;
        while (e > 0) begin v = v * 2.0; e--; end
        while (e < 0) begin v = v / 2.0; e++; end
        return h[15] ? -v : v;
    endfunction

    function automatic logic [15:0] r2h(input real s);
        real  m, sc, fl, fr;
        int   e, qi;
        logic sg;
        if (s == 0.0) return 16'h0000;
        sg = (s < 0.0);
        m  = sg ? -s : s;
        e  = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0) begin m = m * 2.0; e--; end
        sc = m * 1024.0;
        fl = $floor(sc);
        fr = sc - fl;
        qi = $rtoi(fl);
        if (fr > 0.5 || (fr == 0.5 && qi % 2 == 1)) qi++;
        if (qi == 2048) begin qi = 1024; e++; end
        if (e + 15 <= 0) return {sg, 15'h0000};
        if (e + 15 >= 31) return {sg, 5'h1F, 10'h000};
        return {sg, 5'(e + 15), 10'(qi - 1024)};
    endfunction

    function automatic logic [15:0] gen_half();
        logic [4:0] ex;
        logic [9:0] mt;
        if ($urandom_range(0, 15) == 0) return 16'h0000;
        ex = 5'($urandom_range(10, 21));
        mt = 10'($urandom_range(0, (ex == 5'd21) ? 575 : 1023));
        return {1'($urandom_range(0, 1)), ex, mt};
    endfunction

    localparam int NDIR = 28;
    logic [15:0] dir_a [NDIR] = '{
        16'h3C00, 16'h3E00, 16'h5640, 16'h6800, 16'h6800, 16'h7BFF, 16'h7C00,
        16'h7E00, 16'h0000, 16'h8000, 16'h0000, 16'h7C00, 16'hFC00, 16'h7C00,
        16'h3C00, 16'h0001, 16'h8200, 16'hC000, 16'h3C00, 16'h3C00, 16'h3C01,
        16'h3C00, 16'h3C00, 16'h0800, 16'h0600, 16'h8600, 16'h7BFF, 16'h7D00};
    logic [15:0] dir_b [NDIR] = '{
        16'h3C00, 16'hB800, 16'hD640, 16'h3C00, 16'h4200, 16'h7BFF, 16'hFC00,
        16'h3C00, 16'h0000, 16'h8000, 16'h8000, 16'h3C00, 16'hFC00, 16'h7C00,
        16'hBC00, 16'h0000, 16'h3C00, 16'h3C00, 16'h1400, 16'h1000, 16'h1000,
        16'h0400, 16'h8400, 16'h8400, 16'h8400, 16'h0400, 16'h4C00, 16'hFC00};
    logic [15:0] dir_e [NDIR] = '{
        16'h4000, 16'h3C00, 16'h0000, 16'h6800, 16'h6802, 16'h7C00, 16'h7E00,
        16'h7E00, 16'h0000, 16'h8000, 16'h0000, 16'h7C00, 16'hFC00, 16'h7C00,
        16'h0000, 16'h0000, 16'h3C00, 16'hBC00, 16'h3C01, 16'h3C00, 16'h3C02,
        16'h3C00, 16'h3C00, 16'h0400, 16'h0000, 16'h8000, 16'h7C00, 16'h7E00};

    initial begin
        logic [15:0] x, y;
        rst_n = 1'b1;
        a     = 16'h3C00;
        b     = 16'h3C00;
        // Reset held with live operands must keep result at zero.
        repeat (3) drive(1'b1, 16'h3C00, 16'h3C00, 16'h0000, "rst_hold");
        for (int i = 0; i < NDIR; i++)
            drive(1'b0, dir_a[i], dir_b[i], dir_e[i], $sformatf("dir%0d_%h_%h", i, dir_a[i], dir_b[i]));
        for (int i = 0; i <= 1000; i++) begin
            x = gen_half();
            y = gen_half();
            if (i == 500) drive(1'b1, x, y, 16'h0000, "rst_mid");
            else          drive(1'b0, x, y, r2h(h2r(x) + h2r(y)), $sformatf("rand_%h_%h", x, y));
        end
        for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
        if (q.size() > 0) begin
            failures += q.size();
            $display("FAIL drain pending=%0d got=%0d want=0", q.size(), q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d got=running want=finished", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule
